// File: rtl/pipeline_stall_ctrl_if.sv
// Stall/flush controller bus: hazard, memory-wait and branch inputs plus
// per-stage enables, flushes, PC redirect and the IF/ID instruction path.
interface pipeline_stall_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             hazard_stall;
  logic             IM_stall;
  logic             DM_stall;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  inst_in;
  logic             pc_we;
  logic             pc_sel_target;
  logic [XLEN-1:0]  pc_target;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [XLEN-1:0]  inst_out;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hazard_stall, IM_stall, DM_stall,
    output branch_taken, branch_target, inst_in,
    input  pc_we, pc_sel_target, pc_target,
    input  if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  if_id_flush, id_ex_flush, inst_out, stall_cnt
  );

  modport slave (
    input  hazard_stall, IM_stall, DM_stall,
    input  branch_taken, branch_target, inst_in,
    output pc_we, pc_sel_target, pc_target,
    output if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output if_id_flush, id_ex_flush, inst_out, stall_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: freeze, redirect, load-use bubble,
// deferred redirect, fetch hold buffer, saturating stall counter.
// Ports: clk, rst (sync, active-high), bus (slave modport of the _if).
module pipeline_stall_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipeline_stall_ctrl_if.slave bus
);

  logic             r_flush_pending;
  logic [XLEN-1:0]  r_tgt_q;
  logic             r_hold_valid;
  logic [XLEN-1:0]  r_hold_q;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_busy;
  logic w_redirect;
  logic w_do_redirect;
  logic w_pc_we;
  logic w_if_id_we;
  logic w_id_ex_we;
  logic w_ex_mem_we;
  logic w_mem_wb_we;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_sel;

  assign w_mem_busy = bus.IM_stall | bus.DM_stall;
  assign w_redirect = bus.branch_taken | r_flush_pending;

  always_comb begin
    w_pc_we       = 1'b0;
    w_if_id_we    = 1'b0;
    w_id_ex_we    = 1'b0;
    w_ex_mem_we   = 1'b0;
    w_mem_wb_we   = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_sel         = 1'b0;
    w_do_redirect = 1'b0;
    if (rst) begin
      w_pc_we = 1'b0;
    end else if (w_mem_busy) begin
      w_pc_we = 1'b0;
    end else if (w_redirect) begin
      // stalled instruction is killed by the flush, so no bubble needed
      w_pc_we       = 1'b1;
      w_if_id_we    = 1'b1;
      w_id_ex_we    = 1'b1;
      w_ex_mem_we   = 1'b1;
      w_mem_wb_we   = 1'b1;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_sel         = 1'b1;
      w_do_redirect = 1'b1;
    end else if (bus.hazard_stall) begin
      w_id_ex_we    = 1'b1;
      w_id_ex_flush = 1'b1;
      w_ex_mem_we   = 1'b1;
      w_mem_wb_we   = 1'b1;
    end else begin
      w_pc_we     = 1'b1;
      w_if_id_we  = 1'b1;
      w_id_ex_we  = 1'b1;
      w_ex_mem_we = 1'b1;
      w_mem_wb_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_pending <= 1'b0;
      r_tgt_q         <= '0;
    end else if (w_do_redirect) begin
      r_flush_pending <= 1'b0;
    end else if (w_mem_busy && bus.branch_taken) begin
      r_flush_pending <= 1'b1;
      r_tgt_q         <= bus.branch_target;
    end
  end

  // a fetch returned while IF/ID is frozen is parked until IF/ID accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_q     <= '0;
    end else if (w_if_id_we) begin
      r_hold_valid <= 1'b0;
    end else if (!bus.IM_stall && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_q     <= bus.inst_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.pc_we         = w_pc_we;
  assign bus.if_id_we      = w_if_id_we;
  assign bus.id_ex_we      = w_id_ex_we;
  assign bus.ex_mem_we     = w_ex_mem_we;
  assign bus.mem_wb_we     = w_mem_wb_we;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_flush   = w_id_ex_flush;
  assign bus.pc_sel_target = w_sel;
  assign bus.pc_target     = bus.branch_taken ? bus.branch_target : r_tgt_q;
  assign bus.inst_out      = (!rst && r_hold_valid) ? r_hold_q : bus.inst_in;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule
